// File: rtl/dcache_ctrl.sv
// Blocking, direct-mapped, write-through data cache for the memory stage.
// Read misses refill a whole 4-doubleword line; stores write through without allocating.
module dcache_ctrl #(
    parameter int ADDR_BITS  = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [63:0]          addr,
    input  logic [63:0]          data_in,
    input  logic                 rd_en,
    input  logic                 write_en,
    output logic [63:0]          data_out,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [63:0]          mem_wdata,
    input  logic [63:0]          mem_rdata,
    input  logic                 mem_ack
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - 5 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESUME} state_t;

    state_t                 state, state_nxt;
    logic [LINES-1:0]       valid;
    logic [TAG_BITS-1:0]    tag_store [LINES];
    logic [63:0]            words [LINES*4];
    logic [ADDR_BITS-1:3]   lat_addr;
    logic [63:0]            lat_data;
    logic                   lat_write;
    logic [1:0]             beat;

    logic [1:0]             offset, lat_offset;
    logic [INDEX_BITS-1:0]  index, lat_index;
    logic [TAG_BITS-1:0]    tag, lat_tag;
    logic                   hit;
    logic                   unused_addr_bits;

    assign offset     = addr[4:3];
    assign index      = addr[4+INDEX_BITS:5];
    assign tag        = addr[ADDR_BITS-1:5+INDEX_BITS];
    assign lat_offset = lat_addr[4:3];
    assign lat_index  = lat_addr[4+INDEX_BITS:5];
    assign lat_tag    = lat_addr[ADDR_BITS-1:5+INDEX_BITS];
    assign hit        = valid[index] && (tag_store[index] == tag);
    assign unused_addr_bits = ^{addr[63:ADDR_BITS], addr[2:0]};

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        data_out  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (write_en) begin
                    stall     = 1'b1;
                    state_nxt = WRITE;
                end else if (rd_en) begin
                    if (hit) begin
                        data_out = words[{index, offset}];
                    end else begin
                        stall     = 1'b1;
                        state_nxt = REFILL;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {lat_tag, lat_index, beat, 3'b000};
                if (mem_ack && beat == 2'd3) state_nxt = RESUME;
            end
            WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {lat_addr, 3'b000};
                mem_wdata = lat_data;
                if (mem_ack) state_nxt = RESUME;
            end
            RESUME: begin
                data_out  = lat_write ? lat_data : words[{lat_index, lat_offset}];
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset silences every output regardless of the state held in the flops.
        if (!reset_n) begin
            stall     = 1'b0;
            data_out  = '0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            valid <= '0;
            beat  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && !write_en && rd_en && !hit) begin
                valid[index] <= 1'b0;
                beat         <= 2'd0;
            end
            if (state == REFILL && mem_ack) begin
                beat <= beat + 2'd1;
                if (beat == 2'd3) valid[lat_index] <= 1'b1;
            end
        end
    end

    // Datapath storage carries no reset; validity alone guards stale contents.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state == IDLE && write_en) begin
                lat_addr  <= addr[ADDR_BITS-1:3];
                lat_data  <= data_in;
                lat_write <= 1'b1;
                if (hit) words[{index, offset}] <= data_in;
            end else if (state == IDLE && rd_en && !hit) begin
                lat_addr  <= addr[ADDR_BITS-1:3];
                lat_write <= 1'b0;
            end
            if (state == REFILL && mem_ack) begin
                words[{lat_index, beat}] <= mem_rdata;
                if (beat == 2'd3) tag_store[lat_index] <= lat_tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed loads/stores, a backing-memory model
// with configurable latency, and a monitor that checks data on each completion.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] addr, data_in, data_out, mem_wdata, mem_rdata;
    logic        rd_en, write_en, stall, mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [63:0] wdata;
    } txn_t;

    logic [63:0] exp_q [$];
    string       name_q [$];
    txn_t        txq [$];
    logic [63:0] bmem [8192];
    int          mem_wait = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    dcache_ctrl #(.ADDR_BITS(16), .INDEX_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .data_in(data_in),
        .rd_en(rd_en), .write_en(write_en), .data_out(data_out), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Backing memory: acks after mem_wait idle request cycles, checks request stability.
    initial begin
        txn_t held;
        int   wcnt = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        held      = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wcnt == 0) held = '{mem_we, mem_addr, mem_wdata};
                else check("mem_hold", {mem_we, mem_addr, mem_wdata}, held);
                if (wcnt >= mem_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = bmem[mem_addr[15:3]];
                    if (mem_we) bmem[mem_addr[15:3]] = mem_wdata;
                    txq.push_back('{mem_we, mem_addr, mem_wdata});
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every unstalled cycle with a live request is a completion.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && !stall && (rd_en || write_en)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_completion: got data %0h, expected none", data_out);
                end else begin
                    check(name_q.pop_front(), data_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [63:0] a,
                                 input logic [63:0] d, input int wait_c, input int exp_stalls,
                                 input logic [63:0] exp_data, input string name);
        int stalls = 0;
        mem_wait = wait_c;
        exp_q.push_back(exp_data);
        name_q.push_back(name);
        rd_en = rd; write_en = wr; addr = a; data_in = d;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 50) break;
        end
        check({name, "_stalls"}, stalls, exp_stalls);
        @(posedge clk); #1;
        rd_en = 1'b0; write_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic checkOutput(input logic we, input logic [15:0] a, input logic [63:0] wd,
                               input string name);
        if (txq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: got no memory transaction, expected addr %0h", name, a);
        end else begin
            check(name, txq.pop_front(), {we, a, wd});
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) bmem[i] = 64'hDEAD_0000 + 64'(i);
        for (int i = 0; i < 4; i++) begin
            bmem[8 + i]   = 64'hA0 + 64'(i);
            bmem[136 + i] = 64'hB0 + 64'(i);
            bmem[16 + i]  = 64'hC0 + 64'(i);
        end
        reset_n = 1'b0; rd_en = 1'b1; write_en = 1'b0; addr = 64'h40; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {stall, mem_req, mem_we, data_out}, '0);
        rd_en = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {stall, mem_req}, '0);
        @(posedge clk); #1;

        applyStimulus(1, 0, 64'h40, 0, 0, 5, 64'hA0, "miss_0040");
        for (int b = 0; b < 4; b++) checkOutput(0, 16'h40 + 16'(8 * b), 0, "refill_0040");
        check("no_extra_txn_1", txq.size(), 0);

        applyStimulus(1, 0, 64'h50, 0, 0, 0, 64'hA2, "hit_0050");
        check("hit_no_mem", txq.size(), 0);

        applyStimulus(0, 1, 64'h48, 64'h1234, 3, 5, 64'h1234, "store_hit_0048");
        checkOutput(1, 16'h48, 64'h1234, "write_0048");
        applyStimulus(1, 0, 64'h48, 0, 0, 0, 64'h1234, "hit_0048_after_store");

        applyStimulus(0, 1, 64'h440, 64'h5555, 0, 2, 64'h5555, "store_miss_0440");
        checkOutput(1, 16'h440, 64'h5555, "write_0440");
        applyStimulus(1, 0, 64'h40, 0, 0, 0, 64'hA0, "hit_0040_kept");
        check("kept_no_mem", txq.size(), 0);
        applyStimulus(1, 0, 64'h440, 0, 0, 5, 64'h5555, "miss_0440");
        for (int b = 0; b < 4; b++) checkOutput(0, 16'h440 + 16'(8 * b), 0, "refill_0440");

        applyStimulus(1, 1, 64'h450, 64'h77, 0, 2, 64'h77, "rd_wr_both");
        checkOutput(1, 16'h450, 64'h77, "write_0450");
        check("both_no_refill", txq.size(), 0);
        applyStimulus(1, 0, 64'h450, 0, 0, 0, 64'h77, "hit_0450");

        // Reset while beat 2 of a refill is on the bus.
        mem_wait = 0;
        rd_en = 1'b1; addr = 64'h80;
        repeat (4) @(negedge clk);
        check("refill_beat2_addr", mem_addr, 16'h90);
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("reset_mid_refill", {stall, mem_req}, '0);
        #2 rd_en = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        check("idle_after_abort", {stall, mem_req}, '0);
        txq.delete();
        @(posedge clk); #1;

        applyStimulus(1, 0, 64'h80, 0, 0, 5, 64'hC0, "reload_0080");
        for (int b = 0; b < 4; b++) checkOutput(0, 16'h80 + 16'(8 * b), 0, "refill_0080");
        applyStimulus(1, 0, 64'h58, 0, 1, 9, 64'hA3, "miss_0058_after_reset");
        for (int b = 0; b < 4; b++) checkOutput(0, 16'h40 + 16'(8 * b), 0, "refill_0040_again");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of test, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
